// File: rtl/velocity_cell_pingpong.sv
// Per-cell velocity store with two ping-pong banks: the active bank serves reads,
// the shadow bank is filled in append order, and a three-state handshake swaps them.
module velocity_cell_pingpong #(
  parameter int unsigned COMPONENT_WIDTH = 32,
  parameter int unsigned DATA_WIDTH      = 3 * COMPONENT_WIDTH,
  parameter int unsigned PARTICLE_NUM    = 220,
  parameter int unsigned ADDR_WIDTH      = 8
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  swap_req,
  output logic                  swap_done,
  output logic                  busy,
  output logic                  active_bank,
  output logic [ADDR_WIDTH-1:0] active_count,
  output logic [ADDR_WIDTH-1:0] shadow_count,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    SWAP
  } state_e;

  state_e                  state_q;
  logic                    active_bank_q;
  logic [ADDR_WIDTH-1:0]   active_count_q;
  logic [ADDR_WIDTH-1:0]   shadow_count_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    rd_valid_q;
  logic                    swap_done_q;
  logic                    overflow_q;

  logic [DATA_WIDTH-1:0]   bank0_mem [PARTICLE_NUM];
  logic [DATA_WIDTH-1:0]   bank1_mem [PARTICLE_NUM];

  logic                    idle;
  logic                    shadow_full;
  logic                    rd_accept;
  logic                    wr_accept;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic                    addr_in_range;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   rd_result_d;

  assign idle          = (state_q == IDLE);
  assign shadow_full   = (shadow_count_q == MAX_COUNT);
  assign rd_accept     = rd_en && idle;
  assign wr_accept     = wr_valid && idle && !shadow_full;
  assign wr_addr       = shadow_count_q + 1'b1;
  assign addr_in_range = (rd_addr <= active_count_q) && (32'(rd_addr) < PARTICLE_NUM);
  assign rd_word       = active_bank_q ? bank1_mem[rd_addr] : bank0_mem[rd_addr];

  // Address 0 reports the count; anything past the count reads as zero so stale
  // words left from an earlier timestep never leak out.
  always_comb begin
    // NOTE: default assignment first so every path drives rd_result_d and no latch is inferred.
    rd_result_d = '0;
    if (rd_addr == '0) begin
      rd_result_d = DATA_WIDTH'(active_count_q);
    end else if (addr_in_range) begin
      rd_result_d = rd_word;
    end
  end

  // NOTE: RAM arrays get no reset so they map onto block RAM; the counts gate all reads.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      if (active_bank_q) begin
        bank0_mem[wr_addr] <= wr_data;
      end else begin
        bank1_mem[wr_addr] <= wr_data;
      end
    end
  end

  // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      active_bank_q  <= 1'b0;
      active_count_q <= '0;
      shadow_count_q <= '0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      swap_done_q    <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) begin
        rd_data_q <= rd_result_d;
      end

      case (state_q)
        IDLE: begin
          swap_done_q <= 1'b0;
          if (wr_accept) begin
            shadow_count_q <= wr_addr;
          end
          if (wr_valid && shadow_full) begin
            overflow_q <= 1'b1;
          end
          if (swap_req) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          state_q     <= SWAP;
          swap_done_q <= 1'b1;
        end
        SWAP: begin
          state_q        <= IDLE;
          swap_done_q    <= 1'b0;
          active_bank_q  <= ~active_bank_q;
          active_count_q <= shadow_count_q;
          shadow_count_q <= '0;
        end
        default: begin
          state_q     <= IDLE;
          swap_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign rd_ready     = idle;
  assign wr_ready     = idle && !shadow_full;
  assign busy         = !idle;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign swap_done    = swap_done_q;
  assign active_bank  = active_bank_q;
  assign active_count = active_count_q;
  assign shadow_count = shadow_count_q;
  assign overflow     = overflow_q;

endmodule
